div_issue: RTL and testbench
============================

DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter LAT, default 4, fixed divider latency in cycles from div_vld to div_ack (0 = same cycle).
REQ-003 Parameter DEPTH, default 4, result FIFO entries (power of two, >= 2).
REQ-004 Parameter TAGW, default 5, request tag width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 in_vld  in  1, in_rdy  out  1  request handshake; transfer when both high.
REQ-008 in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 in_a, in_b  in  XLEN  dividend, divisor; in_tag  in  TAGW.
REQ-010 div_a, div_b  out  XLEN, div_vld  out  1  unsigned operands to divider.
REQ-011 div_quo, div_rem  in  XLEN, div_ack  in  1  divider result.
REQ-012 out_vld  out  1, out_rdy  in  1, out_data  out  XLEN, out_tag  out  TAGW  result handshake.
REQ-013 err  out  1  sticky protocol error.

Function
REQ-014 in_rdy SHALL be high iff inflight_cnt + fifo_cnt < DEPTH; a same-cycle pop grants no credit.
REQ-015 On transfer, div_vld SHALL pulse for exactly one cycle, the cycle after acceptance, with registered operands.
REQ-016 Signed ops SHALL present |in_a|, |in_b| as unsigned; unsigned ops pass through unchanged.
REQ-017 Per request, a metadata shift line of LAT+1 stages SHALL carry tag, op, sign of quotient (a^b), sign of remainder (a), special flag, override value.
REQ-018 Divisor zero: special, result quo = all ones, rem = in_a, for all four ops.
REQ-019 DIV/REM with in_a = 2^(XLEN-1), in_b = all ones: special, quo = in_a, rem = 0.
REQ-020 Special requests SHALL still issue to the divider to preserve ordering; override replaces divider result on div_ack.
REQ-021 On div_ack, non-special results SHALL be negated per stored sign for signed ops, select quo or rem per op, push to FIFO with tag.
REQ-022 inflight_cnt: +1 on div_vld, -1 on div_ack, unchanged on both.
REQ-023 div_ack with inflight_cnt = 0, or with meta line empty at output stage, SHALL set err and push nothing.
REQ-024 FIFO: first-word-fallthrough; out_vld = fifo not empty; pop on out_vld & out_rdy; push and pop same cycle when full SHALL both occur.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full/empty by extra pointer bit.
REQ-026 Results SHALL emerge in request order; throughput one per cycle when out_rdy held high.
REQ-027 Latency in_vld accept to out_vld SHALL be LAT+2 cycles.

Reset
REQ-028 While rst low: in_rdy=0, div_vld=0, out_vld=0, err=0, div_a=div_b=0, out_data=0, out_tag=0, counters and pointers 0, meta line invalid.
REQ-029 For LAT+1 cycles after rst rises, div_ack SHALL be ignored (blanking counter) and in_rdy held low; this discards results of operations in flight at reset.

Configuration
REQ-030 Macro DIV_SIGNED_EN: defined, DIV/REM signed per REQ-016/019/021; undefined, in_op[0] ignored, all ops unsigned, no sign logic, REQ-019 inactive.

Verification
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> out_data 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1).
REQ-032 DIVU a=100, b=0 -> 0xFFFFFFFF; REMU -> 100; err stays 0.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; DIV_SIGNED_EN undefined -> DIV gives 0, REM gives 0x80000000.
REQ-034 8 back-to-back requests tags 0..7, out_rdy low -> in_rdy drops after 4 accepts; out_rdy high -> tags 0..7 in order, one per cycle.
REQ-035 Assert rst low with 3 in flight, release -> no out_vld, err 0, in_rdy high exactly LAT+1 cycles after release.
REQ-036 Inject div_ack with nothing in flight -> err=1 and sticky until reset; FIFO count unchanged.

Source files
------------

// File: rtl/div_issue.sv
// div_issue: issue/retire front end for a fixed-latency unsigned divider.
// Requests are accepted under a credit limit, operands are registered and sent
// to the divider, and a metadata shift line of LAT+1 stages travels alongside
// each operation. On div_ack the result is corrected (sign, divide-by-zero,
// overflow) and pushed into a first-word-fallthrough result FIFO.
// Optional feature macro: DIV_SIGNED_EN enables signed DIV/REM handling; when
// undefined, in_op[0] is ignored and every op is treated as unsigned.
module div_issue #(
  parameter int XLEN  = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_vld,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem,
  input  logic            div_ack,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int STG = LAT + 1;
  localparam int BW  = $clog2(LAT + 2);

  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW:0]     LIMIT   = (CW+1)'(DEPTH);

`ifdef DIV_SIGNED_EN
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    logic signed [XLEN-1:0] n;
    n = -v;
    return v[XLEN-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    logic signed [XLEN-1:0] s;
    s = -$signed(v);
    return n ? $unsigned(s) : v;
  endfunction
`endif

  // request decode
  logic            acc;
  logic            rem_sel;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] ovr;
`ifdef DIV_SIGNED_EN
  logic            sgn_op;
  logic            nq;
  logic            nr;
`else
  logic            unused_op0;
`endif

  // credit and control state
  logic [CW-1:0]   inflight_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     credit_sum;
  logic [BW-1:0]   blank_cnt;
  logic            ack_live;
  logic            no_owner;
  logic            ack_bad;
  logic            take;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic [XLEN-1:0] res;

  // metadata shift line
  logic            line_vld  [STG];
  logic [TAGW-1:0] line_tag  [STG];
  logic            line_rem  [STG];
  logic            line_spec [STG];
  logic [XLEN-1:0] line_ovr  [STG];
`ifdef DIV_SIGNED_EN
  logic            line_sgn  [STG];
  logic            line_nq   [STG];
  logic            line_nr   [STG];
`endif

  // result FIFO
  logic [PW:0]     wptr;
  logic [PW:0]     rptr;
  logic            empty;
  logic            full;
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [TAGW-1:0] mem_tag  [DEPTH];

  assign credit_sum = {1'b0, inflight_cnt} + {1'b0, fifo_cnt} + {{CW{1'b0}}, div_vld};
  assign in_rdy     = rst & (blank_cnt == '0) & (credit_sum < LIMIT);
  assign acc        = in_vld & in_rdy;
  assign rem_sel    = in_op[1];
  assign b_zero     = (in_b == '0);

  // operand conditioning and special-case detection at acceptance
  always_comb begin
`ifdef DIV_SIGNED_EN
    sgn_op = ~in_op[0];
    ovf    = sgn_op & (in_a == INT_MIN) & (in_b == ONES);
    nq     = sgn_op & (in_a[XLEN-1] ^ in_b[XLEN-1]);
    nr     = sgn_op & in_a[XLEN-1];
    opa    = sgn_op ? abs_val(in_a) : in_a;
    opb    = sgn_op ? abs_val(in_b) : in_b;
`else
    unused_op0 = in_op[0];
    ovf        = 1'b0;
    opa        = in_a;
    opb        = in_b;
`endif
    special = b_zero | ovf;
    if (b_zero) ovr = rem_sel ? in_a : ONES;
    else        ovr = rem_sel ? '0 : INT_MIN;
  end

  // ---- stage p0: issue registers feeding the divider ----
  // registered operands and a one-cycle div_vld pulse per accepted request
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_vld <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
    end else begin
      div_vld <= acc;
      if (acc) begin
        div_a <= opa;
        div_b <= opb;
      end
    end
  end

  // ---- metadata line: stage 0 loads on acceptance, stage LAT meets div_ack ----
  // valid bits of the metadata line, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STG; k++) line_vld[k] <= 1'b0;
    end else begin
      line_vld[0] <= acc;
      for (int k = 1; k < STG; k++) line_vld[k] <= line_vld[k-1];
    end
  end

  // metadata payload shifts unconditionally; qualified by line_vld
  always_ff @(posedge clk) begin
    line_tag[0]  <= in_tag;
    line_rem[0]  <= rem_sel;
    line_spec[0] <= special;
    line_ovr[0]  <= ovr;
`ifdef DIV_SIGNED_EN
    line_sgn[0]  <= sgn_op;
    line_nq[0]   <= nq;
    line_nr[0]   <= nr;
`endif
    for (int k = 1; k < STG; k++) begin
      line_tag[k]  <= line_tag[k-1];
      line_rem[k]  <= line_rem[k-1];
      line_spec[k] <= line_spec[k-1];
      line_ovr[k]  <= line_ovr[k-1];
`ifdef DIV_SIGNED_EN
      line_sgn[k]  <= line_sgn[k-1];
      line_nq[k]   <= line_nq[k-1];
      line_nr[k]   <= line_nr[k-1];
`endif
    end
  end

  // ---- retire: divider result meets metadata output stage ----
  // an ack is owned if a div_vld is outstanding (the same-cycle one counts for LAT=0)
  assign ack_live = div_ack & (blank_cnt == '0);
  assign no_owner = (inflight_cnt == '0) & ~div_vld;
  assign ack_bad  = ack_live & (no_owner | ~line_vld[LAT]);
  assign take     = ack_live & ~no_owner;
  assign push     = ack_live & ~ack_bad;

  // result selection, sign correction and special override
  always_comb begin
    res = line_rem[LAT] ? div_rem : div_quo;
`ifdef DIV_SIGNED_EN
    if (line_sgn[LAT]) res = neg_if(res, line_rem[LAT] ? line_nr[LAT] : line_nq[LAT]);
`endif
    if (line_spec[LAT]) res = line_ovr[LAT];
  end

  // ---- result FIFO (first-word-fallthrough) ----
  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) & (wptr[PW-1:0] == rptr[PW-1:0]);
  assign fifo_cnt = wptr - rptr;
  assign out_vld  = ~empty;
  assign pop      = out_vld & out_rdy;
  assign push_ok  = push & (~full | pop);
  assign out_data = empty ? '0 : mem_data[rptr[PW-1:0]];
  assign out_tag  = empty ? '0 : mem_tag[rptr[PW-1:0]];

  // control state: blanking, in-flight count, sticky error, FIFO pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_cnt    <= BW'(LAT + 1);
      inflight_cnt <= '0;
      err          <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      if (blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
      inflight_cnt <= inflight_cnt + CW'(div_vld) - CW'(take);
      err          <= err | ack_bad;
      if (push_ok) wptr <= wptr + CW'(1);
      if (pop)     rptr <= rptr + CW'(1);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wptr[PW-1:0]] <= res;
      mem_tag[wptr[PW-1:0]]  <= line_tag[LAT];
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: self-checking bench for div_issue with a fixed-latency divider
// model, a table of operand vectors and a result scoreboard.
module tb_div_issue;

  localparam int XLEN  = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [TAGW-1:0] in_tag;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_vld;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_ack;
  logic            out_vld;
  logic            out_rdy;
  logic [XLEN-1:0] out_data;
  logic [TAGW-1:0] out_tag;
  logic            err;

  div_issue #(.XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b), .div_vld(div_vld),
    .div_quo(div_quo), .div_rem(div_rem), .div_ack(div_ack),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_tag(out_tag),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endfunction

  // fixed-latency divider model: samples div_vld at negedge, answers LAT cycles later
  logic            pv [LAT+1];
  logic [XLEN-1:0] pa [LAT+1];
  logic [XLEN-1:0] pb [LAT+1];
  logic            inject;
  logic            inj_r;

  always @(negedge clk) begin
    pv[0] <= div_vld;
    pa[0] <= div_a;
    pb[0] <= div_b;
    for (int k = 1; k <= LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
    inj_r <= inject;
  end

  assign div_ack = pv[LAT] | inj_r;

  always_comb begin
    div_quo = 32'h1234_5678;
    div_rem = 32'h0BAD_0BAD;
    if (pb[LAT] != '0) begin
      div_quo = pa[LAT] / pb[LAT];
      div_rem = pa[LAT] % pb[LAT];
    end
  end

  // scoreboard
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [TAGW-1:0] tag;
  } sb_item_t;
  sb_item_t sb[$];
  sb_item_t exp_item;

  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
      end else begin
        exp_item = sb.pop_front();
        check("out_data", out_data, exp_item.data);
        check("out_tag", 32'(out_tag), 32'(exp_item.tag));
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] es;
    logic [31:0] eu;
  } vec_t;
  vec_t tbl[17];

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAGW-1:0] tag, input logic [31:0] exp);
    int w;
    w = 0;
    in_vld = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    while (!in_rdy && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_rdy) begin
      check("accept_timeout", 32'(in_rdy), 32'd1);
    end else begin
      sb.push_back('{data: exp, tag: tag});
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int run;
    logic seen;

    tbl[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'h7FFF_FFFC};
    tbl[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'h0000_0001};
    tbl[2]  = '{2'b01, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3]  = '{2'b11, 32'd100,       32'd0,        32'd100,       32'd100};
    tbl[4]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    tbl[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6]  = '{2'b01, 32'd1000,      32'd7,        32'd142,       32'd142};
    tbl[7]  = '{2'b11, 32'd1000,      32'd7,        32'd6,         32'd6};
    tbl[8]  = '{2'b00, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0000};
    tbl[9]  = '{2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'd100};
    tbl[10] = '{2'b00, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[11] = '{2'b10, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FF9C};
    tbl[12] = '{2'b01, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 32'h0FFF_FFFF};
    tbl[13] = '{2'b11, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'hF};
    tbl[14] = '{2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hE,         32'h0};
    tbl[15] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FF9C};
    tbl[16] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0};

    rst = 1'b0; in_vld = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    out_rdy = 1'b0; inject = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_div_vld", 32'(div_vld), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);

    rst = 1'b1;
    n = 0;
    while (!in_rdy && n < 20) begin @(posedge clk); #1; n++; end
    check("blank_after_reset", 32'(n), 32'(LAT + 1));

    // accept-to-out_vld latency
    out_rdy = 1'b1;
    in_vld = 1'b1; in_op = 2'b01; in_a = 32'd50; in_b = 32'd5; in_tag = 5'd1;
    check("rdy_for_latency", 32'(in_rdy), 32'd1);
    sb.push_back('{data: 32'd10, tag: 5'd1});
    n = 0;
    do begin @(posedge clk); #1; in_vld = 1'b0; n++; end while (!out_vld && n < 20);
    check("latency", 32'(n), 32'(LAT + 2));
    drain();

    // operand table, issued back to back
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, TAGW'(i), SGN ? tbl[i].es : tbl[i].eu);
    end
    drain();
    check("err_after_table", 32'(err), 32'd0);

    // credit limit under backpressure, then ordered release
    out_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_vld = 1'b1; in_op = 2'b01; in_a = 32'(acc * 10 + 5); in_b = 32'd3; in_tag = TAGW'(acc);
      if (in_rdy) begin
        sb.push_back('{data: 32'((acc * 10 + 5) / 3), tag: TAGW'(acc)});
        acc++;
      end
      @(posedge clk); #1;
    end
    check("accepts_when_blocked", 32'(acc), 32'd4);
    check("in_rdy_when_full", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    run = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      in_vld = 1'b1; in_op = 2'b01; in_a = 32'(acc * 10 + 5); in_b = 32'd3; in_tag = TAGW'(acc);
      if (c < 4 && out_vld) run++;
      if (in_rdy) begin
        sb.push_back('{data: 32'((acc * 10 + 5) / 3), tag: TAGW'(acc)});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    check("accepts_total", 32'(acc), 32'd8);
    check("out_vld_run", 32'(run), 32'd4);
    drain();

    // spurious div_ack with nothing in flight
    repeat (LAT + 3) @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(posedge clk); #1;
    check("err_on_stray_ack", 32'(err), 32'd1);
    check("no_push_on_stray_ack", 32'(out_vld), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(err), 32'd1);

    // reset with three operations in flight
    send(2'b01, 32'd90, 32'd9, 5'd20, 32'd10);
    send(2'b01, 32'd80, 32'd8, 5'd21, 32'd10);
    send(2'b01, 32'd70, 32'd7, 5'd22, 32'd10);
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("err_cleared_by_reset", 32'(err), 32'd0);
    rst = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!in_rdy && n < 20) begin
      @(posedge clk); #1; n++;
      if (out_vld) seen = 1'b1;
    end
    check("in_rdy_after_release", 32'(n), 32'(LAT + 1));
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (out_vld) seen = 1'b1;
    end
    check("no_stale_out", 32'(seen), 32'd0);
    check("err_after_flush", 32'(err), 32'd0);

    // normal operation resumes after the flush
    send(2'b11, 32'd77, 32'd10, 5'd30, 32'd7);
    drain();
    check("err_final", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
